// File: rtl/ipm_output_arbiter_if.sv
// ---------------------------------------------------------------------------
// ipm_output_arbiter_if
// Bundles the upstream and downstream toggle handshakes of one switch output
// port arbiter.
//   req_up_i          : upstream request toggles, one bit per channel
//   Data_up_i         : upstream flits, channel i at [i*WORD_WIDTH +: WORD_WIDTH]
//   ack_up_o          : upstream ack toggles
//   req_dw_o          : downstream request toggle
//   Data_dw_o         : downstream flit
//   ack_dw_i          : downstream ack toggle
//   PacketEnable_dw_i : downstream can accept a new packet
//   grant_o           : one-hot current owner, zero when idle
//   busy_o            : packet in progress
// Modports: slave = arbiter side, master = environment driving the arbiter.
// ---------------------------------------------------------------------------
interface ipm_output_arbiter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int INPORTS    = 4
);
  logic [INPORTS-1:0]            req_up_i;
  logic [INPORTS*WORD_WIDTH-1:0] Data_up_i;
  logic [INPORTS-1:0]            ack_up_o;
  logic                          req_dw_o;
  logic [WORD_WIDTH-1:0]         Data_dw_o;
  logic                          ack_dw_i;
  logic                          PacketEnable_dw_i;
  logic [INPORTS-1:0]            grant_o;
  logic                          busy_o;

  modport slave (
    input  req_up_i, Data_up_i, ack_dw_i, PacketEnable_dw_i,
    output ack_up_o, req_dw_o, Data_dw_o, grant_o, busy_o
  );

  modport master (
    output req_up_i, Data_up_i, ack_dw_i, PacketEnable_dw_i,
    input  ack_up_o, req_dw_o, Data_dw_o, grant_o, busy_o
  );
endinterface

// File: rtl/ipm_output_arbiter.sv
// ---------------------------------------------------------------------------
// ipm_output_arbiter
// Packet-granular round-robin arbiter sharing one switch output link among
// INPORTS upstream channels using 2-phase (toggle) req/ack handshakes. A
// grant is held from header flit (bit0) to tail flit (bit1) so packets never
// interleave on the output.
// Ports:
//   clk        : clock
//   reset      : synchronous active-high reset
//   bus        : ipm_output_arbiter_if.slave (all handshake/data signals)
//   pkt_cnt_o  : per-input tail-flit counters, CNT_WIDTH bits each
//                (present only when IPM_ARB_PKT_CNT_EN is defined)
// Optional feature macro: IPM_ARB_PKT_CNT_EN
// ---------------------------------------------------------------------------
module ipm_output_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int INPORTS    = 4
`ifdef IPM_ARB_PKT_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic clk,
  input  logic reset,
`ifdef IPM_ARB_PKT_CNT_EN
  output logic [INPORTS*CNT_WIDTH-1:0] pkt_cnt_o,
`endif
  ipm_output_arbiter_if.slave bus
);

  localparam int PTR_W = (INPORTS > 1) ? $clog2(INPORTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD     = 2'd1,
    WAIT_UP = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [PTR_W-1:0]       rr_ptr_r, rr_ptr_nxt_s;
  logic [PTR_W-1:0]       owner_r, owner_nxt_s;
  logic [PTR_W-1:0]       winner_s;
  logic                   found_s;
  logic                   tail_r, tail_nxt_s;
  logic [INPORTS-1:0]     ack_up_r, ack_up_nxt_s;
  logic [INPORTS-1:0]     grant_r, grant_nxt_s;
  logic [INPORTS-1:0]     pending_s, eligible_s;
  logic                   req_dw_r, req_dw_nxt_s;
  logic                   busy_r, busy_nxt_s;
  logic                   out_outstanding_s;
  logic [WORD_WIDTH-1:0]  data_dw_r, data_dw_nxt_s;
  logic [WORD_WIDTH-1:0]  winner_data_s, owner_data_s;
`ifdef IPM_ARB_PKT_CNT_EN
  logic [INPORTS*CNT_WIDTH-1:0] pkt_cnt_r, pkt_cnt_nxt_s;
`endif

  // Pending/eligible per channel; only pending headers may win arbitration.
  always_comb begin
    pending_s  = '0;
    eligible_s = '0;
    for (int i = 0; i < INPORTS; i++) begin
      pending_s[i]  = bus.req_up_i[i] ^ ack_up_r[i];
      eligible_s[i] = pending_s[i] & bus.Data_up_i[i*WORD_WIDTH];
    end
  end

  assign out_outstanding_s = req_dw_r ^ bus.ack_dw_i;

  // Round-robin search: first eligible index starting at rr_ptr, modulo INPORTS.
  always_comb begin
    int idx;
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < INPORTS; k++) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= INPORTS) begin
        idx = idx - INPORTS;
      end else begin
        idx = idx;
      end
      if (!found_s && eligible_s[idx]) begin
        found_s  = 1'b1;
        winner_s = PTR_W'(idx);
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign winner_data_s = bus.Data_up_i[int'(winner_s)*WORD_WIDTH +: WORD_WIDTH];
  assign owner_data_s  = bus.Data_up_i[int'(owner_r)*WORD_WIDTH +: WORD_WIDTH];

  // State register plus all registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
      tail_r    <= 1'b0;
      ack_up_r  <= '0;
      grant_r   <= '0;
      req_dw_r  <= 1'b0;
      busy_r    <= 1'b0;
      data_dw_r <= '0;
`ifdef IPM_ARB_PKT_CNT_EN
      pkt_cnt_r <= '0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
      owner_r   <= owner_nxt_s;
      tail_r    <= tail_nxt_s;
      ack_up_r  <= ack_up_nxt_s;
      grant_r   <= grant_nxt_s;
      req_dw_r  <= req_dw_nxt_s;
      busy_r    <= busy_nxt_s;
      data_dw_r <= data_dw_nxt_s;
`ifdef IPM_ARB_PKT_CNT_EN
      pkt_cnt_r <= pkt_cnt_nxt_s;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.PacketEnable_dw_i && found_s) begin
          state_nxt_s = FWD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FWD: begin
        // tail_r describes the flit currently on the output link.
        if (!out_outstanding_s) begin
          state_nxt_s = tail_r ? IDLE : WAIT_UP;
        end else begin
          state_nxt_s = FWD;
        end
      end
      WAIT_UP: begin
        if (pending_s[owner_r]) begin
          state_nxt_s = FWD;
        end else begin
          state_nxt_s = WAIT_UP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath next values; everything holds unless a transition fires.
  always_comb begin
    rr_ptr_nxt_s  = rr_ptr_r;
    owner_nxt_s   = owner_r;
    tail_nxt_s    = tail_r;
    ack_up_nxt_s  = ack_up_r;
    grant_nxt_s   = grant_r;
    req_dw_nxt_s  = req_dw_r;
    busy_nxt_s    = busy_r;
    data_dw_nxt_s = data_dw_r;
`ifdef IPM_ARB_PKT_CNT_EN
    pkt_cnt_nxt_s = pkt_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.PacketEnable_dw_i && found_s) begin
          owner_nxt_s           = winner_s;
          tail_nxt_s            = winner_data_s[1];
          grant_nxt_s           = '0;
          grant_nxt_s[winner_s] = 1'b1;
          busy_nxt_s            = 1'b1;
          data_dw_nxt_s         = winner_data_s;
          req_dw_nxt_s          = ~req_dw_r;
        end else begin
          busy_nxt_s            = busy_r;
        end
      end
      FWD: begin
        if (!out_outstanding_s) begin
          // Downstream took the flit: only now release the upstream sender.
          ack_up_nxt_s[owner_r] = ~ack_up_r[owner_r];
          if (tail_r) begin
            grant_nxt_s  = '0;
            busy_nxt_s   = 1'b0;
            rr_ptr_nxt_s = (owner_r == PTR_W'(INPORTS - 1)) ? '0 : owner_r + PTR_W'(1);
`ifdef IPM_ARB_PKT_CNT_EN
            pkt_cnt_nxt_s[int'(owner_r)*CNT_WIDTH +: CNT_WIDTH] =
              pkt_cnt_r[int'(owner_r)*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
`endif
          end else begin
            busy_nxt_s   = busy_r;
          end
        end else begin
          busy_nxt_s = busy_r;
        end
      end
      WAIT_UP: begin
        if (pending_s[owner_r]) begin
          data_dw_nxt_s = owner_data_s;
          tail_nxt_s    = owner_data_s[1];
          req_dw_nxt_s  = ~req_dw_r;
        end else begin
          req_dw_nxt_s  = req_dw_r;
        end
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  assign bus.ack_up_o  = ack_up_r;
  assign bus.req_dw_o  = req_dw_r;
  assign bus.Data_dw_o = data_dw_r;
  assign bus.grant_o   = grant_r;
  assign bus.busy_o    = busy_r;
`ifdef IPM_ARB_PKT_CNT_EN
  assign pkt_cnt_o     = pkt_cnt_r;
`endif

endmodule
